// File: rtl/fetch_sequencer.sv
// PC owner and single-outstanding instruction fetch controller with a one-entry output register.
// Optional FETCH_HALT_EN macro adds a HALT state entered when decode accepts a HALT_OPCODE word.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
`ifdef FETCH_HALT_EN
  ,
  parameter logic [5:0] HALT_OPCODE = 6'h3F
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_addr,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [7:0]  instr_pc,
  input  logic        instr_ready,
  output logic        busy
);

`ifdef FETCH_HALT_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FULL, S_DRAIN, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FULL, S_DRAIN} state_t;
`endif

  state_t      r_state;
  logic [7:0]  r_pc;
  logic        r_imem_req;
  logic [7:0]  r_imem_addr;
  logic        r_instr_valid;
  logic [31:0] r_instr_data;
  logic [7:0]  r_instr_pc;

  state_t      w_state;
  logic [7:0]  w_pc;
  logic        w_imem_req;
  logic [7:0]  w_imem_addr;
  logic        w_instr_valid;
  logic [31:0] w_instr_data;
  logic [7:0]  w_instr_pc;
  logic        w_transfer;

  assign w_transfer = r_instr_valid && instr_ready;

  always_comb begin
    // NOTE: every next value defaults to its register so no branch can infer a latch.
    w_state       = r_state;
    w_pc          = r_pc;
    w_imem_req    = r_imem_req;
    w_imem_addr   = r_imem_addr;
    w_instr_valid = r_instr_valid;
    w_instr_data  = r_instr_data;
    w_instr_pc    = r_instr_pc;

    unique case (r_state)
      S_IDLE: begin
        if (redirect_valid) begin
          w_pc = redirect_addr;
        end else if (start) begin
          w_state     = S_FETCH;
          w_imem_req  = 1'b1;
          w_imem_addr = r_pc;
        end
      end

      S_FETCH: begin
        if (redirect_valid) begin
          w_pc = redirect_addr;
          // A completed read is dropped and the request re-aimed; an open one must drain first.
          if (imem_ack) begin
            w_imem_addr = redirect_addr;
          end else begin
            w_state = S_DRAIN;
          end
        end else if (imem_ack) begin
          w_instr_data  = imem_rdata;
          w_instr_pc    = r_imem_addr;
          w_instr_valid = 1'b1;
          w_imem_req    = 1'b0;
          w_pc          = r_imem_addr + 8'd1;
          w_state       = S_FULL;
        end
      end

      S_DRAIN: begin
        if (redirect_valid) begin
          w_pc = redirect_addr;
        end
        if (imem_ack) begin
          w_state     = S_FETCH;
          w_imem_addr = redirect_valid ? redirect_addr : r_pc;
        end
      end

      S_FULL: begin
        if (redirect_valid) begin
          w_instr_valid = 1'b0;
          w_pc          = redirect_addr;
          w_state       = S_FETCH;
          w_imem_req    = 1'b1;
          w_imem_addr   = redirect_addr;
        end else if (w_transfer) begin
          w_instr_valid = 1'b0;
`ifdef FETCH_HALT_EN
          if (r_instr_data[31:26] == HALT_OPCODE) begin
            w_state = S_HALT;
          end else begin
            w_state     = S_FETCH;
            w_imem_req  = 1'b1;
            w_imem_addr = r_pc;
          end
`else
          w_state     = S_FETCH;
          w_imem_req  = 1'b1;
          w_imem_addr = r_pc;
`endif
        end
      end

`ifdef FETCH_HALT_EN
      S_HALT: begin
        if (redirect_valid) begin
          w_pc        = redirect_addr;
          w_state     = S_FETCH;
          w_imem_req  = 1'b1;
          w_imem_addr = redirect_addr;
        end
      end
`endif

      default: begin
        w_state    = S_IDLE;
        w_imem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; blocking ones live in always_comb.
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr_data  <= 32'h0;
      r_instr_pc    <= 8'h00;
    end else begin
      r_state       <= w_state;
      r_pc          <= w_pc;
      r_imem_req    <= w_imem_req;
      r_imem_addr   <= w_imem_addr;
      r_instr_valid <= w_instr_valid;
      r_instr_data  <= w_instr_data;
      r_instr_pc    <= w_instr_pc;
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_valid = r_instr_valid;
  assign instr_data  = r_instr_data;
  assign instr_pc    = r_instr_pc;
  assign busy        = (r_state == S_FETCH) || (r_state == S_FULL) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: a memory responder with programmable ack latency,
// queues of expected request addresses and delivered words, plus directed checks per scenario.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] data;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_addr = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [7:0]  instr_pc;
  logic        instr_ready = 1'b0;
  logic        busy;

  logic        mem_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  int          ack_delay = 0;
  bit          halt_word = 1'b0;

  int          tests_run = 0;
  int          fails = 0;

  logic [7:0]  exp_req[$];
  out_t        exp_out[$];

  assign imem_ack   = mem_ack | stray_ack;
  assign imem_rdata = mem_rdata;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .busy          (busy)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    if (halt_word && a == 8'h02) return {6'h3F, 10'h000, 8'h5A, a};
    return {8'h12, a, ~a, a ^ 8'h5A};
  endfunction

  task automatic push_req(input logic [7:0] a);
    exp_req.push_back(a);
  endtask

  task automatic push_out(input logic [7:0] a);
    out_t e;
    e.pc   = a;
    e.data = mem_word(a);
    exp_out.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [7:0] a);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (imem_req === 1'b1 && imem_addr === a) return;
    end
    tests_run++; fails++;
    $display("FAIL wait_req: no request to %h within 40 cycles (req=%b addr=%h)", a, imem_req, imem_addr);
  endtask

  task automatic wait_out(input logic [7:0] a);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (instr_valid === 1'b1 && instr_pc === a) return;
    end
    tests_run++; fails++;
    $display("FAIL wait_out: word for %h not held within 40 cycles (valid=%b pc=%h)", a, instr_valid, instr_pc);
  endtask

  // Memory responder: acks after ack_delay waiting cycles, then drops ack for one cycle.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (imem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(imem_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : mon_req
    logic [7:0] a;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req === 1'b1 && mem_ack === 1'b1) begin
        tests_run++;
        if (exp_req.size() == 0) begin
          fails++;
          $display("FAIL req_unexpected: completed read at %h, required none", imem_addr);
        end else begin
          a = exp_req.pop_front();
          if (imem_addr !== a) begin
            fails++;
            $display("FAIL req_addr: got %h, required %h", imem_addr, a);
          end
        end
      end
    end
  end

  initial begin : mon_out
    out_t e;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        tests_run++;
        if (exp_out.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected: pc=%h data=%h delivered, required none", instr_pc, instr_data);
        end else begin
          e = exp_out.pop_front();
          if (instr_pc !== e.pc || instr_data !== e.data) begin
            fails++;
            $display("FAIL out_word: got pc=%h data=%h, required pc=%h data=%h",
                     instr_pc, instr_data, e.pc, e.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) tick();
    tests_run += 6;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b, required 0", imem_req); end
    if (imem_addr !== 8'h00) begin fails++; $display("FAIL rst_addr: got %h, required 00", imem_addr); end
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
    if (instr_data !== 32'h0) begin fails++; $display("FAIL rst_data: got %h, required 0", instr_data); end
    if (instr_pc !== 8'h00) begin fails++; $display("FAIL rst_pc: got %h, required 00", instr_pc); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) push_req(8'(i));
    for (int i = 0; i < 3; i++) push_out(8'(i));
    ack_delay   = 0;
    instr_ready = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tests_run += 3;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL start_req: got %b, required 1", imem_req); end
    if (imem_addr !== 8'h00) begin fails++; $display("FAIL start_addr: got %h, required 00", imem_addr); end
    if (busy !== 1'b1) begin fails++; $display("FAIL start_busy: got %b, required 1", busy); end
    tick();
    tests_run += 3;
    if (instr_valid !== 1'b1) begin fails++; $display("FAIL ack_valid: got %b, required 1", instr_valid); end
    if (instr_pc !== 8'h00) begin fails++; $display("FAIL ack_pc: got %h, required 00", instr_pc); end
    if (imem_req !== 1'b0) begin fails++; $display("FAIL ack_req_drop: got %b, required 0", imem_req); end
    tick();
    tests_run += 2;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL next_req: got %b, required 1", imem_req); end
    if (imem_addr !== 8'h01) begin fails++; $display("FAIL next_addr: got %h, required 01", imem_addr); end
    wait_out(8'h03);
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    push_out(8'h03);
    push_req(8'h04);
    push_out(8'h04);
    for (int i = 0; i < 5; i++) begin
      tests_run += 3;
      if (instr_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b, required 1", i, instr_valid); end
      if (instr_data !== mem_word(8'h03)) begin
        fails++; $display("FAIL stall_data[%0d]: got %h, required %h", i, instr_data, mem_word(8'h03));
      end
      if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req[%0d]: got %b, required 0", i, imem_req); end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    tests_run += 3;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL resume_req: got %b, required 1", imem_req); end
    if (imem_addr !== 8'h04) begin fails++; $display("FAIL resume_addr: got %h, required 04", imem_addr); end
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL resume_valid: got %b, required 0", instr_valid); end
  endtask

  task automatic test_redirect_drain();
    tick();
    ack_delay = 3;
    push_req(8'h05); push_req(8'h40); push_out(8'h40);
    push_req(8'h41); push_req(8'h50); push_out(8'h50);
    wait_req(8'h05);
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    tick();
    redirect_valid = 1'b0;
    tests_run += 3;
    if (busy !== 1'b1) begin fails++; $display("FAIL drain_busy: got %b, required 1", busy); end
    if (imem_req !== 1'b1) begin fails++; $display("FAIL drain_req: got %b, required 1", imem_req); end
    if (imem_addr !== 8'h05) begin fails++; $display("FAIL drain_addr: got %h, required 05", imem_addr); end
    wait_req(8'h40);
    tests_run++;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL drain_discard: got valid %b, required 0", instr_valid); end
    wait_req(8'h41);
    redirect_valid = 1'b1;
    redirect_addr  = 8'h48;
    tick();
    redirect_addr = 8'h50;
    tests_run++;
    if (imem_addr !== 8'h41) begin fails++; $display("FAIL drain2_addr: got %h, required 41", imem_addr); end
    tick();
    redirect_valid = 1'b0;
    wait_req(8'h50);
    tests_run++;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL drain2_discard: got valid %b, required 0", instr_valid); end
    ack_delay = 0;
  endtask

  task automatic test_full_redirect();
    push_req(8'h10);
    wait_out(8'h50);
    redirect_valid = 1'b1;
    redirect_addr  = 8'h10;
    tick();
    redirect_valid = 1'b0;
    tests_run += 3;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b, required 0", instr_valid); end
    if (imem_req !== 1'b1) begin fails++; $display("FAIL flush_req: got %b, required 1", imem_req); end
    if (imem_addr !== 8'h10) begin fails++; $display("FAIL flush_addr: got %h, required 10", imem_addr); end
  endtask

  task automatic test_reset_midread();
    reset = 1'b1;
    tick();
    tests_run += 6;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL mid_rst_req: got %b, required 0", imem_req); end
    if (imem_addr !== 8'h00) begin fails++; $display("FAIL mid_rst_addr: got %h, required 00", imem_addr); end
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b, required 0", instr_valid); end
    if (instr_data !== 32'h0) begin fails++; $display("FAIL mid_rst_data: got %h, required 0", instr_data); end
    if (instr_pc !== 8'h00) begin fails++; $display("FAIL mid_rst_pc: got %h, required 00", instr_pc); end
    if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
    reset = 1'b0;
    tick();
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tests_run += 3;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL stray_valid: got %b, required 0", instr_valid); end
    if (imem_req !== 1'b0) begin fails++; $display("FAIL stray_req: got %b, required 0", imem_req); end
    if (busy !== 1'b0) begin fails++; $display("FAIL stray_busy: got %b, required 0", busy); end
    tick();
    tests_run++;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL stray_valid_late: got %b, required 0", instr_valid); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_addr  = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    tests_run += 2;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL idle_redir_req: got %b, required 0", imem_req); end
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_redir_busy: got %b, required 0", busy); end
    push_req(8'hFF); push_req(8'h00); push_req(8'h01);
    push_out(8'hFF); push_out(8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run += 2;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL wrap_req: got %b, required 1", imem_req); end
    if (imem_addr !== 8'hFF) begin fails++; $display("FAIL wrap_addr: got %h, required FF", imem_addr); end
    wait_out(8'h00);
    tests_run++;
    if (instr_data !== mem_word(8'h00)) begin
      fails++; $display("FAIL wrap_data: got %h, required %h", instr_data, mem_word(8'h00));
    end
    tick();
    tests_run += 2;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL wrap_next_req: got %b, required 1", imem_req); end
    if (imem_addr !== 8'h01) begin fails++; $display("FAIL wrap_next_addr: got %h, required 01", imem_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    halt_word = 1'b1;
    push_req(8'h00); push_req(8'h01); push_req(8'h02); push_req(8'h20);
    push_out(8'h00); push_out(8'h01); push_out(8'h02);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_out(8'h02);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run += 2;
      if (imem_req !== 1'b0) begin fails++; $display("FAIL halt_req[%0d]: got %b, required 0", i, imem_req); end
      if (busy !== 1'b0) begin fails++; $display("FAIL halt_busy[%0d]: got %b, required 0", i, busy); end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_addr  = 8'h20;
    tick();
    redirect_valid = 1'b0;
    tests_run += 2;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL halt_redir_req: got %b, required 1", imem_req); end
    if (imem_addr !== 8'h20) begin fails++; $display("FAIL halt_redir_addr: got %h, required 20", imem_addr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    halt_word = 1'b0;
    tick();
  endtask
`endif

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_full_redirect();
    test_reset_midread();
    test_wrap();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    tick();
    tests_run += 2;
    if (exp_req.size() != 0) begin fails++; $display("FAIL req_leftover: %0d reads never completed, required 0", exp_req.size()); end
    if (exp_out.size() != 0) begin fails++; $display("FAIL out_leftover: %0d words never delivered, required 0", exp_out.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
